// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are fixed up in one final cycle.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    input  logic             hilo_rd_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADJ  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   hi_w;
    logic [WIDTH-1:0]   lo_w;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               accept;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   orig_a;
    logic [WIDTH-1:0]   adj_hi;
    logic [WIDTH-1:0]   adj_lo;

    assign accept   = start_i & ~flush_i;
    assign a_neg_in = ~op_i[0] & src_a_i[WIDTH-1];
    assign b_neg_in = ~op_i[0] & src_b_i[WIDTH-1];
    assign mag_a_in = a_neg_in ? -src_a_i : src_a_i;
    assign mag_b_in = b_neg_in ? -src_b_i : src_b_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = RUN;
            RUN: begin
                if (flush_i) begin
                    next_state = IDLE;
                end else if (cnt == LAST) begin
                    next_state = ADJ;
                end
            end
            ADJ:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration: multiply keeps {partial, multiplier} in {hi_w, lo_w};
    // divide keeps {remainder, dividend/quotient} in {hi_w, lo_w}.
    always_comb begin
        mul_sum   = {1'b0, hi_w} + (lo_w[0] ? {1'b0, a_reg} : '0);
        div_shift = {hi_w, lo_w[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        step_hi   = '0;
        step_lo   = '0;
        if (is_div) begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {lo_w[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_w[WIDTH-1:1]};
        end
    end

    // Most-negative / -1 needs no special case: the magnitude quotient 2^(W-1)
    // negates back to itself and the remainder is zero.
    always_comb begin
        prod   = {hi_w, lo_w};
        orig_a = sign_a ? -a_reg : a_reg;
        adj_hi = '0;
        adj_lo = '0;
        if (!is_div) begin
            if (sign_a ^ sign_b) begin
                prod = -prod;
            end
            adj_hi = prod[2*WIDTH-1:WIDTH];
            adj_lo = prod[WIDTH-1:0];
        end else if (b_reg == '0) begin
            adj_hi = orig_a;
            adj_lo = '1;
        end else begin
            adj_hi = sign_a ? -hi_w : hi_w;
            adj_lo = (sign_a ^ sign_b) ? -lo_w : lo_w;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            hi_w   <= '0;
            lo_w   <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= op_i[1];
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        a_reg  <= mag_a_in;
                        b_reg  <= mag_b_in;
                        hi_w   <= '0;
                        lo_w   <= op_i[1] ? mag_a_in : mag_b_in;
                    end else if (!start_i) begin
                        if (mthi_i) hi_r <= wdata_i;
                        if (mtlo_i) lo_r <= wdata_i;
                    end
                end
                RUN: begin
                    if (!flush_i) begin
                        cnt  <= cnt + CNT_W'(1);
                        hi_w <= step_hi;
                        lo_w <= step_lo;
                    end
                end
                ADJ: begin
                    if (!flush_i) begin
                        hi_r   <= adj_hi;
                        lo_r   <= adj_lo;
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_o    = hi_r;
    assign lo_o    = lo_r;
    assign done_o  = done_r;
    assign busy_o  = (state != IDLE);
    assign stall_o = busy_o & (start_i | hilo_rd_i | mthi_i | mtlo_i);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: table of directed operations plus
// hand-written stall, flush and reset sequences.
module tb_ex_muldiv_unit;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic [1:0]       op_i = 2'b00;
    logic [WIDTH-1:0] src_a_i = '0;
    logic [WIDTH-1:0] src_b_i = '0;
    logic             flush_i = 1'b0;
    logic             hilo_rd_i = 1'b0;
    logic             mthi_i = 1'b0;
    logic             mtlo_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .src_a_i   (src_a_i),
        .src_b_i   (src_b_i),
        .flush_i   (flush_i),
        .hilo_rd_i (hilo_rd_i),
        .mthi_i    (mthi_i),
        .mtlo_i    (mtlo_i),
        .wdata_i   (wdata_i),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pulses start_i across one rising edge; returns #1 after that edge (edge k).
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        op_i    = op;
        src_a_i = a;
        src_b_i = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // Counts edges after the start edge until done_o is seen at a negedge.
    task automatic waitDone(output int edges, output bit busy_ok, output bit stall_ok);
        edges    = 0;
        busy_ok  = 1'b1;
        stall_ok = 1'b1;
        while (edges < 200) begin
            @(negedge clk_i);
            if (done_o) break;
            if (!busy_o) busy_ok = 1'b0;
            if (hilo_rd_i && !stall_o) stall_ok = 1'b0;
            @(posedge clk_i);
            edges++;
        end
    endtask

    initial begin
        int  edges;
        bit  busy_ok;
        bit  stall_ok;

        vecs[0]  = '{"multu_ffff_x2", MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE};
        vecs[1]  = '{"mult_m3_x5",    MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div_m7_2",      DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7_0",      DIVU,  32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",       DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"divu_100_3",    DIVU,  32'd100,      32'd3,        32'h00000001, 32'h00000021};
        vecs[6]  = '{"mult_m1_m1",    MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[7]  = '{"multu_max_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[8]  = '{"div_7_m2",      DIV,   32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"div_m7_0",      DIV,   32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{"mult_min_x2",   MULT,  32'h80000000, 32'h2,        32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{"divu_max_16",   DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
        vecs[12] = '{"mult_x_0",      MULT,  32'h12345678, 32'h0,        32'h00000000, 32'h00000000};

        // Reset state, with requests asserted to show stall stays low
        start_i   = 1'b1;
        hilo_rd_i = 1'b1;
        #12;
        checkOutput("reset_hi", hi_o, 0);
        checkOutput("reset_lo", lo_o, 0);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_stall", stall_o, 0);
        start_i   = 1'b0;
        hilo_rd_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone(edges, busy_ok, stall_ok);
            checkOutput({vecs[i].name, "_latency"}, edges, LAT);
            checkOutput({vecs[i].name, "_busy"}, busy_ok, 1);
            checkOutput({vecs[i].name, "_hi"}, hi_o, vecs[i].hi);
            checkOutput({vecs[i].name, "_lo"}, lo_o, vecs[i].lo);
            checkOutput({vecs[i].name, "_busy_in_done"}, busy_o, 0);
            @(posedge clk_i);
            #1;
        end

        // Held MFLO stalls until the done cycle; a start while busy is dropped
        applyStimulus(MULTU, 32'd6, 32'd7);
        hilo_rd_i = 1'b1;
        fork
            begin
                repeat (5) @(posedge clk_i);
                #1;
                op_i = MULTU; src_a_i = 32'd100; src_b_i = 32'd100; start_i = 1'b1;
                @(posedge clk_i);
                #1;
                start_i = 1'b0;
            end
            waitDone(edges, busy_ok, stall_ok);
        join
        checkOutput("stall_latency", edges, LAT);
        checkOutput("stall_held", stall_ok, 1);
        checkOutput("stall_done_cycle", stall_o, 0);
        checkOutput("stall_lo", lo_o, 42);
        checkOutput("stall_hi", hi_o, 0);
        hilo_rd_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("second_start_ignored", busy_o, 0);
        checkOutput("second_start_lo", lo_o, 42);

        // MTHI+MTLO together, then flush in RUN cycle 10
        @(negedge clk_i);
        mthi_i = 1'b1; mtlo_i = 1'b1; wdata_i = 32'h11111111;
        @(posedge clk_i);
        #1;
        mthi_i = 1'b0; mtlo_i = 1'b0;
        checkOutput("mt_both_hi", hi_o, 32'h11111111);
        checkOutput("mt_both_lo", lo_o, 32'h11111111);
        applyStimulus(DIVU, 32'd100, 32'd3);
        repeat (10) @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        busy_ok = 1'b1;
        stall_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (busy_o) busy_ok = 1'b0;
            if (done_o) stall_ok = 1'b0;
        end
        checkOutput("flush_run_idle", busy_ok, 1);
        checkOutput("flush_run_no_done", stall_ok, 1);
        checkOutput("flush_run_hi", hi_o, 32'h11111111);
        checkOutput("flush_run_lo", lo_o, 32'h11111111);
        @(negedge clk_i);
        mtlo_i = 1'b1; wdata_i = 32'h0000ABCD;
        @(posedge clk_i);
        #1;
        mtlo_i = 1'b0;
        checkOutput("mtlo_lo", lo_o, 32'h0000ABCD);
        checkOutput("mtlo_hi", hi_o, 32'h11111111);

        // Flush in the ADJ cycle blocks the HI/LO write
        applyStimulus(MULTU, 32'hFFFFFFFF, 32'h2);
        repeat (WIDTH) @(posedge clk_i);
        #1;
        checkOutput("adj_busy", busy_o, 1);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        @(negedge clk_i);
        checkOutput("flush_adj_done", done_o, 0);
        checkOutput("flush_adj_busy", busy_o, 0);
        checkOutput("flush_adj_lo", lo_o, 32'h0000ABCD);

        // start together with flush in IDLE does not start
        @(negedge clk_i);
        start_i = 1'b1; flush_i = 1'b1; op_i = MULTU; src_a_i = 32'd5; src_b_i = 32'd5;
        @(posedge clk_i);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        checkOutput("flush_idle_no_start", busy_o, 0);

        // Async reset mid-RUN clears everything without a clock edge
        applyStimulus(MULTU, 32'hFFFFFFFF, 32'h2);
        repeat (5) @(posedge clk_i);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", busy_o, 0);
        checkOutput("async_rst_hi", hi_o, 0);
        checkOutput("async_rst_lo", lo_o, 0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Fresh op after reset; concurrent MTHI loses to start
        mthi_i  = 1'b1;
        wdata_i = 32'hDEADBEEF;
        applyStimulus(MULTU, 32'd3, 32'd4);
        mthi_i = 1'b0;
        waitDone(edges, busy_ok, stall_ok);
        checkOutput("post_rst_latency", edges, LAT);
        checkOutput("post_rst_lo", lo_o, 12);
        checkOutput("post_rst_hi", hi_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU into private HI/LO registers.
- It also services MTHI/MTLO writes and provides HI/LO values for MFHI/MFLO.
- While an operation is in flight, it raises stall_o. stall_o drives the stall_i inputs of the IF/ID and ID/EX pipeline registers and freezes the front end until the result is ready.

Parameters:
- WIDTH, 32, operand and HI/LO width (even, >=4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  EX holds a MULT/MULTU/DIV/DIVU; request to begin.
- op_i  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a_i  in  WIDTH  rs operand (multiplicand / dividend).
- src_b_i  in  WIDTH  rt operand (multiplier / divisor).
- flush_i  in  1  abort in-flight operation (branch/exception squash).
- hilo_rd_i  in  1  EX holds MFHI/MFLO.
- mthi_i  in  1  write wdata_i to HI.
- mtlo_i  in  1  write wdata_i to LO.
- wdata_i  in  WIDTH  MTHI/MTLO data.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- busy_o  out  1  operation in flight.
- done_o  out  1  one-cycle pulse; HI/LO just updated by an operation.
- stall_o  out  1  pipeline stall request.

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=LO=0, busy_o=0, done_o=0, counter=0, internal operand regs=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: accepts work.
  - RUN: one iteration per cycle, WIDTH cycles.
  - ADJ: one cycle for sign correction and HI/LO write.
- Transitions:
  - IDLE→RUN on start_i=1 & flush_i=0. At that edge, latch op_i, the operand magnitudes (absolute values for signed ops) and the sign flags; clear the counter.
  - RUN→ADJ when counter reaches WIDTH-1.
  - ADJ→IDLE always. At this edge HI/LO are written and done_o=1 for the following cycle.
- Latency: start accepted at edge k; HI/LO updated at edge k+WIDTH+1; done_o high in cycle k+WIDTH+1 only.
- busy_o=1 in RUN and ADJ (registered from state, so low in IDLE).
- stall_o: combinational, = busy_o & (start_i | hilo_rd_i | mthi_i | mtlo_i).
  - Requests arriving while busy are not executed; upstream holds them until stall_o drops.
  - In the done_o cycle busy_o=0, so the held request proceeds and reads the new HI/LO.
- Multiply:
  - Unsigned shift-add on magnitudes, 2*WIDTH product, {HI,LO}=product.
  - Signed: negate the 2*WIDTH product in ADJ if the operand signs differ.
- Divide:
  - Restoring radix-2 on magnitudes; LO=quotient, HI=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero, both DIV and DIVU: LO={WIDTH{1}}, HI=original src_a_i. No trap; latency unchanged.
- Signed overflow, DIV of most-negative by -1: LO=most-negative value (0x80000000), HI=0.
- MTHI/MTLO in IDLE: HI or LO takes wdata_i at the next edge. Both together write both.
- start_i together with mthi_i/mtlo_i in IDLE: start wins; writes are ignored.
- flush_i:
  - In RUN/ADJ: next edge → IDLE; HI/LO unchanged; no done_o.
  - In IDLE with start_i=1: no start.
  - flush_i has priority over the ADJ write.
- hi_o/lo_o always reflect the registers; they are not updated during RUN.
- Counter never wraps: it is cleared on entry to RUN and only increments in RUN.

Test Plan:
- MULTU a=0xFFFFFFFF, b=2, start at edge k → busy_o=1 k..k+32, done_o=1 in cycle k+33, HI=0x00000001, LO=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7; DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- Start MULTU 6×7, then hold hilo_rd_i=1 from the next cycle → stall_o=1 through ADJ, 0 in the done cycle with LO=42; a second start_i while busy is ignored (HI/LO reflect only the first operation).
- HI=LO=0x11111111, start DIVU 100/3, assert flush_i in RUN cycle 10 → IDLE next edge, no done_o, HI/LO stay 0x11111111; then mtlo_i with wdata_i=0xABCD in IDLE → LO=0xABCD at next edge.
- Drop rst_n mid-edge during RUN cycle 5 → busy_o, HI, LO immediately 0 without a clock edge; after release, a fresh MULTU 3×4 gives LO=12, HI=0.
